uart_rx_buffered: RTL

UART_RX_BUFFERED -- requirements
Module: uart_rx_buffered

---
 rtl/uart_rx_buffered.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_buffered.sv
// UART 8N1 receiver with a one-entry valid/ready holding register and sticky overrun flag.
// Define UART_RX_FRAMING_EN to add the framing_err port and to discard bytes that have a low stop bit.
module uart_rx_buffered #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    input  logic       data_out_ready,
    input  logic       clear_flags,
    output logic       overrun
`ifdef UART_RX_FRAMING_EN
    ,
    output logic       framing_err
`endif
);

    localparam int BIT_CYC  = CLOCK_FREQ / BAUD_RATE;
    localparam int HALF_CYC = BIT_CYC / 2;
    localparam int CNT_W    = $clog2(BIT_CYC) + 1;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYC - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;
    logic             sync_ff;
    logic             rx_s;
    logic             commit;
    logic             stop_sample;

`ifdef UART_RX_FRAMING_EN
    logic             stop_fail;
    logic             frame_bad;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_ff <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            sync_ff <= serial_in;
            rx_s    <= sync_ff;
        end
    end

    // The stop-bit midpoint is where a finished byte is either committed or rejected.
`ifdef UART_RX_FRAMING_EN
    always_comb begin
        stop_sample = (state == STOP) && (cnt == BIT_LAST) && !stop_fail;
        commit      = stop_sample && rx_s;
        frame_bad   = stop_sample && !rx_s;
    end
`else
    always_comb begin
        stop_sample = (state == STOP) && (cnt == BIT_LAST);
        commit      = stop_sample;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= 3'd0;
            shift_reg <= 8'h00;
`ifdef UART_RX_FRAMING_EN
            stop_fail <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rx_s) begin
                        state <= START;
                    end
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= 3'd0;
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt               <= '0;
                        shift_reg[bit_idx] <= rx_s;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
`ifdef UART_RX_FRAMING_EN
                    // A bad stop bit parks here until the line returns high, so the
                    // remainder of the low stop bit cannot be taken as a new start.
                    if (stop_fail) begin
                        if (rx_s) begin
                            stop_fail <= 1'b0;
                            cnt       <= '0;
                            state     <= IDLE;
                        end
                    end else if (cnt == BIT_LAST) begin
                        if (rx_s) begin
                            cnt   <= '0;
                            state <= IDLE;
                        end else begin
                            stop_fail <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`else
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // A commit may refill the holding register in the same cycle it is drained.
    always_ff @(posedge clk) begin
        if (!rst) begin
            data_out       <= 8'h00;
            data_out_valid <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            if (commit && (!data_out_valid || data_out_ready)) begin
                data_out       <= shift_reg;
                data_out_valid <= 1'b1;
            end else if (data_out_valid && data_out_ready) begin
                data_out_valid <= 1'b0;
            end

            if (commit && data_out_valid && !data_out_ready) begin
                overrun <= 1'b1;
            end else if (clear_flags) begin
                overrun <= 1'b0;
            end
        end
    end

`ifdef UART_RX_FRAMING_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            framing_err <= 1'b0;
        end else if (frame_bad) begin
            framing_err <= 1'b1;
        end else if (clear_flags) begin
            framing_err <= 1'b0;
        end
    end
`endif

endmodule
